byte_mem_hs: RTL and testbench

//  Parametrised byte-addressed single-port memory with four-phase REQ/ACK handshake.
//  Big-endian word view: byte at ADDR maps to DOUT/DIN[DW-1:DW-8], byte ADDR+NB-1 maps to [7:0].

---
 rtl/byte_mem_hs.sv | 100 ++++++++++
 tb/tb_byte_mem_hs.sv | 150 +++++++++++++++
 2 files changed

// File: rtl/byte_mem_hs.sv
// byte_mem_hs: byte-addressed big-endian memory behind a four-phase REQ/ACK handshake (range/alignment checking enabled by BYTE_MEM_CHECK_EN)
module byte_mem_hs #(
    parameter int          DW       = 16,
    parameter int          AW       = 16,
    parameter int          DEPTH    = 16384,
    parameter int          LATENCY  = 0,
    parameter logic [7:0]  INIT_VAL = 8'h00
) (
    input  logic            CLK,
    input  logic            nRST,
    input  logic [AW-1:0]   ADDR,
    input  logic [DW-1:0]   DIN,
    input  logic [DW/8-1:0] BE,
    input  logic            WEN,
    input  logic            REQ,
    output logic [DW-1:0]   DOUT,
    output logic            ACK,
    output logic            ERR
);
    localparam int NB = DW / 8;
    localparam int IW = $clog2(DEPTH);

    typedef enum logic [1:0] {IDLE, WAIT, DO, HOLD} state_t;

    state_t          state, nxt;
    logic [AW-1:0]   a;
    logic [DW-1:0]   d;
    logic [NB-1:0]   be;
    logic            w;
    logic [3:0]      cnt;
    logic            bad;
    logic [7:0]      mem [DEPTH] = '{default: INIT_VAL};

    function automatic logic [IW-1:0] idx(input int k);
        return IW'((32'(a) + 32'(k)) % 32'(DEPTH));
    endfunction

`ifdef BYTE_MEM_CHECK_EN
    assign bad = 32'(a) >= 32'(DEPTH) || 32'(a) + 32'(NB) > 32'(DEPTH) || 32'(a) % 32'(NB) != 0;
`else
    assign bad = 1'b0;
`endif

    // state register
    always_ff @(posedge CLK)
        state <= nRST ? nxt : IDLE;

    // next state: a wait stage always precedes the access so ACK lands LATENCY+2 edges after capture
    always_comb begin
        nxt = state;
        case (state)
            IDLE:    nxt = REQ ? WAIT : IDLE;
            WAIT:    nxt = cnt == 4'd0 ? DO : WAIT;
            DO:      nxt = HOLD;
            HOLD:    nxt = REQ ? HOLD : IDLE;
            default: nxt = IDLE;
        endcase
    end

    // capture the request, count wait cycles, perform reads and drive the handshake outputs
    always_ff @(posedge CLK) begin
        if (!nRST) begin
            ACK  <= 1'b0;
            ERR  <= 1'b0;
            DOUT <= '0;
            cnt  <= 4'd0;
        end else begin
            case (state)
                IDLE: if (REQ) begin
                    a   <= ADDR;
                    d   <= DIN;
                    be  <= BE;
                    w   <= WEN;
                    cnt <= 4'(LATENCY);
                end
                WAIT: if (cnt != 4'd0) cnt <= cnt - 4'd1;
                DO: begin
                    ACK <= 1'b1;
                    ERR <= bad;
                    if (bad)
                        DOUT <= '0;
                    else if (!w)
                        for (int k = 0; k < NB; k++)
                            DOUT[DW-1-8*k -: 8] <= mem[idx(k)];
                end
                HOLD: if (!REQ) begin
                    ACK <= 1'b0;
                    ERR <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    // byte-lane writes; reset never clears the array and discards a pending write
    always_ff @(posedge CLK)
        if (nRST && state == DO && w && !bad)
            for (int k = 0; k < NB; k++)
                if (be[NB-1-k]) mem[idx(k)] <= d[DW-1-8*k -: 8];
endmodule

// File: tb/tb_byte_mem_hs.sv
// tb_byte_mem_hs: directed checks of byte_mem_hs (default, 32-bit and LATENCY=3 instances)
module tb_byte_mem_hs;
    logic        CLK = 1'b0;
    logic        nRST = 1'b0;
    logic [15:0] ADDR = '0;
    logic [31:0] DIN = '0;
    logic [3:0]  BE = '0;
    logic        WEN = 1'b0;
    logic [2:0]  req = '0;
    logic [2:0]  ack, err;
    logic [15:0] d0, d2;
    logic [31:0] d1;
    int checks = 0;
    int passed = 0;

    always #5 CLK = ~CLK;

    byte_mem_hs u0 (.CLK(CLK), .nRST(nRST), .ADDR(ADDR), .DIN(DIN[15:0]), .BE(BE[1:0]), .WEN(WEN),
                    .REQ(req[0]), .DOUT(d0), .ACK(ack[0]), .ERR(err[0]));
    byte_mem_hs #(.DW(32)) u1 (.CLK(CLK), .nRST(nRST), .ADDR(ADDR), .DIN(DIN), .BE(BE), .WEN(WEN),
                    .REQ(req[1]), .DOUT(d1), .ACK(ack[1]), .ERR(err[1]));
    byte_mem_hs #(.LATENCY(3)) u2 (.CLK(CLK), .nRST(nRST), .ADDR(ADDR), .DIN(DIN[15:0]), .BE(BE[1:0]), .WEN(WEN),
                    .REQ(req[2]), .DOUT(d2), .ACK(ack[2]), .ERR(err[2]));

    task automatic xact(input int u, input logic [15:0] a, input logic [31:0] dv, input logic [3:0] bv,
                        input logic wv, output logic [31:0] q, output logic e, output int lat);
        int n = 0;
        @(negedge CLK);
        ADDR = a; DIN = dv; BE = bv; WEN = wv; req[u] = 1'b1;
        do begin @(posedge CLK); #1; n++; end while (!ack[u] && n < 40);
        if (!ack[u]) begin checks++; $display("FAIL ack_timeout unit %0d addr %h", u, a); end
        q = u == 1 ? d1 : u == 0 ? {16'h0, d0} : {16'h0, d2};
        e = err[u];
        lat = n - 1;
        req[u] = 1'b0;
        n = 0;
        do begin @(posedge CLK); #1; n++; end while (ack[u] && n < 40);
    endtask

    task automatic test_reset;
        repeat (2) @(posedge CLK);
        #1;
        checks++; if (ack !== 3'b000) $display("FAIL reset_ack got %b want 000", ack); else passed++;
        checks++; if (err !== 3'b000) $display("FAIL reset_err got %b want 000", err); else passed++;
        checks++; if ({d0, d1, d2} !== 64'h0) $display("FAIL reset_dout got %h want 0", {d0, d1, d2}); else passed++;
        @(negedge CLK) nRST = 1'b1;
    endtask

    task automatic test_default_read;
        logic [31:0] q; logic e; int lat;
        xact(0, 16'h0010, 0, 4'b0011, 1'b0, q, e, lat);
        checks++; if (q !== 32'h0000) $display("FAIL read_init got %h want 0000", q); else passed++;
        checks++; if (lat !== 2) $display("FAIL read_latency got %0d want 2", lat); else passed++;
        checks++; if (e !== 1'b0) $display("FAIL read_err got %b want 0", e); else passed++;
    endtask

    task automatic test_write_read;
        logic [31:0] q; logic e; int lat;
        xact(0, 16'h0100, 32'hBEEF, 4'b0011, 1'b1, q, e, lat);
`ifndef BYTE_MEM_CHECK_EN
        xact(0, 16'h00FF, 0, 4'b0011, 1'b0, q, e, lat);
        checks++; if (q !== 32'h00BE) $display("FAIL byte_0100 got %h want 00BE", q); else passed++;
`endif
        xact(0, 16'h0100, 0, 4'b0000, 1'b0, q, e, lat);
        checks++; if (q !== 32'hBEEF) $display("FAIL readback got %h want BEEF", q); else passed++;
    endtask

    task automatic test_byte_enable;
        logic [31:0] q; logic e; int lat;
        xact(0, 16'h0100, 32'h1234, 4'b0001, 1'b1, q, e, lat);
        checks++; if (q !== 32'hBEEF) $display("FAIL write_keeps_dout got %h want BEEF", q); else passed++;
        xact(0, 16'h0100, 0, 4'b0000, 1'b0, q, e, lat);
        checks++; if (q !== 32'hBE34) $display("FAIL be_01 got %h want BE34", q); else passed++;
        xact(1, 16'h0000, 32'h11223344, 4'b1111, 1'b1, q, e, lat);
        xact(1, 16'h0000, 32'hAA000000, 4'b1000, 1'b1, q, e, lat);
        xact(1, 16'h0000, 0, 4'b0000, 1'b0, q, e, lat);
        checks++; if (q !== 32'hAA223344) $display("FAIL be_1000_w32 got %h want AA223344", q); else passed++;
        checks++; if (lat !== 2) $display("FAIL w32_latency got %0d want 2", lat); else passed++;
    endtask

    task automatic test_latency;
        logic [31:0] q; logic e; int lat; int n = 0; int hi = 0; logic held = 1'b1;
        @(negedge CLK);
        ADDR = 16'h0040; WEN = 1'b0; req[2] = 1'b1;
        do begin @(posedge CLK); #1; n++; end while (!ack[2] && n < 40);
        checks++; if (n - 1 !== 5) $display("FAIL lat3_ack_edge got %0d want 5", n - 1); else passed++;
        repeat (3) begin @(posedge CLK); #1; held &= ack[2]; end
        checks++; if (held !== 1'b1) $display("FAIL lat3_ack_held got %b want 1", held); else passed++;
        req[2] = 1'b0;
        @(posedge CLK); #1;
        checks++; if (ack[2] !== 1'b0) $display("FAIL lat3_ack_fall got %b want 0", ack[2]); else passed++;
        @(negedge CLK);
        ADDR = 16'h0020; DIN = 32'hCAFE; BE = 4'b0011; WEN = 1'b1; req[2] = 1'b1;
        @(negedge CLK) req[2] = 1'b0;
        repeat (12) begin @(posedge CLK); #1; hi += int'(ack[2]); end
        checks++; if (hi !== 1) $display("FAIL drop_in_wait_pulse got %0d want 1", hi); else passed++;
        xact(2, 16'h0020, 0, 4'b0000, 1'b0, q, e, lat);
        checks++; if (q !== 32'hCAFE) $display("FAIL drop_in_wait_write got %h want CAFE", q); else passed++;
        checks++; if (lat !== 5) $display("FAIL lat3_xact got %0d want 5", lat); else passed++;
    endtask

    task automatic test_wrap;
        logic [31:0] q; logic e; int lat;
        xact(0, 16'h3FFF, 32'hA55A, 4'b0011, 1'b1, q, e, lat);
`ifdef BYTE_MEM_CHECK_EN
        checks++; if (e !== 1'b1) $display("FAIL wrap_err got %b want 1", e); else passed++;
        xact(0, 16'h3FFE, 0, 4'b0000, 1'b0, q, e, lat);
        checks++; if (q !== 32'h0000) $display("FAIL wrap_top_untouched got %h want 0000", q); else passed++;
        xact(0, 16'h0000, 0, 4'b0000, 1'b0, q, e, lat);
        checks++; if (q !== 32'h0000) $display("FAIL wrap_low_untouched got %h want 0000", q); else passed++;
        xact(0, 16'h0101, 0, 4'b0000, 1'b0, q, e, lat);
        checks++; if ({e, q} !== 33'h100000000) $display("FAIL misaligned got err %b dout %h want err 1 dout 0", e, q); else passed++;
`else
        checks++; if (e !== 1'b0) $display("FAIL wrap_err got %b want 0", e); else passed++;
        xact(0, 16'h3FFE, 0, 4'b0000, 1'b0, q, e, lat);
        checks++; if (q !== 32'h00A5) $display("FAIL wrap_byte_3fff got %h want 00A5", q); else passed++;
        xact(0, 16'h0000, 0, 4'b0000, 1'b0, q, e, lat);
        checks++; if (q !== 32'h5A00) $display("FAIL wrap_byte_0000 got %h want 5A00", q); else passed++;
        xact(0, 16'h0101, 0, 4'b0000, 1'b0, q, e, lat);
        checks++; if ({e, q} !== 33'h000003400) $display("FAIL misaligned got err %b dout %h want err 0 dout 3400", e, q); else passed++;
`endif
    endtask

    task automatic test_reset_mid;
        logic [31:0] q; logic e; int lat;
        xact(2, 16'h0030, 32'h7788, 4'b0011, 1'b1, q, e, lat);
        @(negedge CLK);
        ADDR = 16'h0030; DIN = 32'h9999; BE = 4'b0011; WEN = 1'b1; req[2] = 1'b1;
        @(negedge CLK);
        nRST = 1'b0; req[2] = 1'b0;
        @(posedge CLK); #1;
        checks++; if ({ack[2], d2} !== 17'h0) $display("FAIL reset_mid got ack %b dout %h want 0 0000", ack[2], d2); else passed++;
        @(negedge CLK) nRST = 1'b1;
        xact(2, 16'h0030, 0, 4'b0000, 1'b0, q, e, lat);
        checks++; if (q !== 32'h7788) $display("FAIL reset_mid_no_write got %h want 7788", q); else passed++;
        checks++; if (lat !== 5) $display("FAIL reset_mid_next got %0d want 5", lat); else passed++;
    endtask

    initial begin
        test_reset;
        test_default_read;
        test_write_read;
        test_byte_enable;
        test_latency;
        test_wrap;
        test_reset_mid;
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
